// File: rtl/mac64_acc.sv
// 64-bit accumulator for a stream of multiplier products. Packet results are held
// until consumed; signed/unsigned overflow is optionally saturated.
module mac64_acc #(
  parameter int unsigned SAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic        mode,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] acc,
  output logic [15:0] cnt,
  output logic        ovf
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        mode_q, mode_d;

  logic [63:0] prod;
  logic [63:0] sum;
  logic        carry;
  logic        accept;
  logic        eff_mode;
  logic        ovf_beat;

  always_comb begin
    prod         = {hi, lo};
    {carry, sum} = {1'b0, acc_q} + {1'b0, prod};
    accept       = in_valid && (state_q == ST_ACC);
    // The first beat of a packet supplies the mode; later beats reuse the latched copy.
    eff_mode     = (cnt_q == '0) ? mode : mode_q;
    ovf_beat     = eff_mode ? ((acc_q[63] == prod[63]) && (sum[63] != acc_q[63]))
                            : carry;

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;

    unique case (state_q)
      ST_ACC: begin
        if (accept) begin
          mode_d = eff_mode;
          acc_d  = sum;
          if (ovf_beat) begin
            ovf_d = 1'b1;
            if (SAT != 0) begin
              // Signed overflow direction follows the common sign of the two addends.
              if (!eff_mode)      acc_d = '1;
              else if (acc_q[63]) acc_d = 64'h8000_0000_0000_0000;
              else                acc_d = 64'h7FFF_FFFF_FFFF_FFFF;
            end
          end
          if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
          if (in_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          mode_d  = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign acc       = acc_q;
  assign cnt       = cnt_q;
  assign ovf       = ovf_q;

endmodule
